// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues in-order imem requests, buffers
// returned words with their PCs and hands them to decode; honours redirects.
module fetch_unit #(
  parameter int             XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int             DEPTH    = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            instr_valid,
  input  logic            dec_ready,
  output logic [XLEN-1:0] Instr,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PCPlus4,
  input  logic            PCSrc,
  input  logic [XLEN-1:0] PCTarget,
  output logic            misalign_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t          state_reg;
  logic [XLEN-1:0] fetch_pc_reg;
  logic [XLEN-1:0] rsp_pc_reg;
  logic [CW-1:0]   outstanding_reg;
  logic [CW-1:0]   count_reg;
  logic [CW-1:0]   drop_cnt_reg;
  logic [AW-1:0]   head_reg;
  logic [AW-1:0]   tail_reg;
  logic            misalign_err_reg;

  logic [XLEN-1:0] buf_data [DEPTH];
  logic [XLEN-1:0] buf_pc   [DEPTH];

  logic [CW:0]     inflight;
  logic            req_fire;
  logic            pop;
  logic            redirect;
  logic            push;
  logic [CW-1:0]   outstanding_next;

  // Requests in flight plus buffered words never exceed DEPTH, so a push can't overflow.
  assign inflight       = {1'b0, outstanding_reg} + {1'b0, count_reg};
  assign imem_req_valid = (state_reg == RUN) && (inflight < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_reg;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign instr_valid = (count_reg != '0);
  assign pop         = instr_valid && dec_ready;
  assign redirect    = pop && PCSrc;
  assign push        = imem_rsp_valid && (drop_cnt_reg == '0) && (state_reg != HALT) && !redirect;

  assign outstanding_next = outstanding_reg + CW'(req_fire) - CW'(imem_rsp_valid);

  assign Instr        = instr_valid ? buf_data[head_reg] : NOP;
  assign PC           = instr_valid ? buf_pc[head_reg] : rsp_pc_reg;
  assign PCPlus4      = PC + XLEN'(4);
  assign misalign_err = misalign_err_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= BOOT;
      fetch_pc_reg     <= RESET_PC;
      rsp_pc_reg       <= RESET_PC;
      outstanding_reg  <= '0;
      count_reg        <= '0;
      drop_cnt_reg     <= '0;
      head_reg         <= '0;
      tail_reg         <= '0;
      misalign_err_reg <= 1'b0;
    end else begin
      outstanding_reg <= outstanding_next;
      count_reg       <= count_reg + CW'(push) - CW'(pop);
      if (state_reg == BOOT)
        state_reg <= RUN;
      if (req_fire)
        fetch_pc_reg <= fetch_pc_reg + XLEN'(4);
      if (imem_rsp_valid && (drop_cnt_reg != '0))
        drop_cnt_reg <= drop_cnt_reg - CW'(1);
      if (push) begin
        tail_reg   <= tail_reg + AW'(1);
        rsp_pc_reg <= rsp_pc_reg + XLEN'(4);
      end
      if (pop)
        head_reg <= head_reg + AW'(1);
      // Redirect wins over everything above: wrong-path words still in flight get dropped.
      if (redirect) begin
        count_reg    <= '0;
        head_reg     <= '0;
        tail_reg     <= '0;
        drop_cnt_reg <= outstanding_next;
        fetch_pc_reg <= PCTarget;
        rsp_pc_reg   <= PCTarget;
        if (PCTarget[1:0] != 2'b00) begin
          misalign_err_reg <= 1'b1;
          state_reg        <= HALT;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_data[tail_reg] <= imem_rsp_data;
      buf_pc[tail_reg]   <= rsp_pc_reg;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model with configurable latency and a
// scoreboard of expected consumed PCs, plus request-address tracking.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        dec_ready;
  logic [31:0] Instr;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        PCSrc;
  logic [31:0] PCTarget;
  logic        misalign_err;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .dec_ready(dec_ready),
    .Instr(Instr), .PC(PC), .PCPlus4(PCPlus4),
    .PCSrc(PCSrc), .PCTarget(PCTarget), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_fire = 0;
  int mem_lat = 1;
  bit rand_ready = 1'b0;
  int cycle_cnt = 0;
  logic [31:0] exp_req = 32'h0;
  logic [31:0] exp_q [$];

  typedef struct { logic [31:0] addr; int due; } pend_t;
  pend_t pend [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory: word = address, in-order, responds mem_lat cycles after acceptance.
  always @(posedge clk) begin
    cycle_cnt++;
    if (reset) begin
      pend.delete();
      imem_rsp_valid <= 1'b0;
      imem_rsp_data  <= 32'h0;
    end else begin
      imem_rsp_valid <= 1'b0;
      if (imem_req_valid && imem_req_ready)
        pend.push_back('{imem_req_addr, cycle_cnt + mem_lat - 1});
      if (pend.size() > 0 && pend[0].due <= cycle_cnt) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data  <= pend[0].addr;
        void'(pend.pop_front());
      end
    end
  end

  // Monitor: request addresses and consumed words, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      exp_req = 32'h0;
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        check("req_addr", imem_req_addr, exp_req);
        exp_req = exp_req + 32'd4;
        n_fire++;
      end
      if (instr_valid && dec_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_pc", PC, 32'hxxxx_xxxx);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          $display("consume pc=%h instr=%h redirect=%0d", PC, Instr, PCSrc);
          check("pc", PC, e);
          check("instr", Instr, e);
          check("pcplus4", PCPlus4, e + 32'd4);
        end
        if (PCSrc) exp_req = PCTarget;
      end
    end
  end

  // Consume n words starting at start_pc; optionally redirect on the last one.
  task automatic stream(input logic [31:0] start_pc, input int n, input bit redir,
                        input logic [31:0] tgt);
    int got = 0;
    int cyc = 0;
    for (int i = 0; i < n; i++) exp_q.push_back(start_pc + 32'(4 * i));
    while (got < n && cyc < 300) begin
      if (rand_ready) imem_req_ready = 1'($urandom_range(0, 1));
      if (instr_valid) begin
        dec_ready = 1'b1;
        PCSrc     = redir && (got == n - 1);
        PCTarget  = tgt;
        got++;
      end else begin
        dec_ready = 1'b0;
        PCSrc     = 1'b0;
      end
      tick();
      cyc++;
    end
    dec_ready      = 1'b0;
    PCSrc          = 1'b0;
    imem_req_ready = 1'b1;
    if (got < n) check("stream_timeout", 32'(got), 32'(n));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    reset = 1'b1; imem_req_ready = 1'b1; dec_ready = 1'b0;
    PCSrc = 1'b0; PCTarget = 32'h0;
    do_reset();
    check("rst_req_valid", 32'(imem_req_valid), 32'h0);
    check("rst_instr_valid", 32'(instr_valid), 32'h0);
    check("rst_instr", Instr, 32'h0000_0013);
    check("rst_pc", PC, 32'h0);
    check("rst_pcplus4", PCPlus4, 32'h4);
    check("rst_misalign", 32'(misalign_err), 32'h0);

    reset = 1'b0;
    n_fire = 0;
    check("boot_no_req", 32'(imem_req_valid), 32'h0);
    tick();
    check("first_req_valid", 32'(imem_req_valid), 32'h1);
    check("first_req_addr", imem_req_addr, 32'h0);

    // Back-pressure: decode stalled, only DEPTH requests go out.
    repeat (6) tick();
    check("bp_fire_count", 32'(n_fire), 32'd2);
    check("bp_req_valid", 32'(imem_req_valid), 32'h0);
    check("bp_instr_valid", 32'(instr_valid), 32'h1);
    check("bp_pc_hold", PC, 32'h0);
    check("bp_instr_hold", Instr, 32'h0);

    stream(32'h0, 3, 1'b0, 32'h0);
    mem_lat = 2;
    stream(32'hC, 1, 1'b1, 32'h100);
    stream(32'h100, 4, 1'b1, 32'hFFFF_FFF8);
    mem_lat = 1;
    stream(32'hFFFF_FFF8, 4, 1'b1, 32'h40);
    rand_ready = 1'b1;
    stream(32'h40, 6, 1'b1, 32'h102);
    rand_ready = 1'b0;

    check("misalign_set", 32'(misalign_err), 32'h1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("halt_req_valid", 32'(imem_req_valid), 32'h0);
      check("halt_instr_valid", 32'(instr_valid), 32'h0);
    end

    do_reset();
    check("rst2_misalign", 32'(misalign_err), 32'h0);
    reset = 1'b0;
    stream(32'h0, 3, 1'b0, 32'h0);
    check("sb_drained", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
